// File: rtl/tpu_package.sv
// tpu_package: shared array geometry, weight row type and weight-load FSM states
package tpu_package;
  localparam int MUL_SIZE = 32;
  localparam int DATA_W = 8;
  localparam int TILE_CNT_W = 9;
  localparam int ROW_IDX_W = $clog2(MUL_SIZE);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(MUL_SIZE - 1);
  typedef logic [MUL_SIZE*DATA_W-1:0] weight_row_t;
  typedef enum logic [2:0] {RESET, IDLE, LOAD, WAIT_FREE, DONE} wl_state_t;
endpackage

// File: rtl/pingpong_occupancy_tracker.sv
// pingpong_occupancy_tracker: two-buffer fill count, write/read pointers and sticky underflow (in: tile_loaded, consume; out: full_cnt, wr_buf, rd_buf, underflow_err)
module pingpong_occupancy_tracker (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tile_loaded,
  input  logic       consume,
  output logic [1:0] full_cnt,
  output logic       wr_buf,
  output logic       rd_buf,
  output logic       underflow_err
);
  logic take;
  assign take = consume && full_cnt != 2'd0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_cnt <= 2'd0;
      wr_buf <= 1'b0;
      rd_buf <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      full_cnt <= full_cnt + {1'b0, tile_loaded} - {1'b0, take};
      wr_buf <= wr_buf ^ tile_loaded;
      rd_buf <= rd_buf ^ take;
      underflow_err <= underflow_err | (consume && !take);
    end
  end
endmodule

// File: rtl/weight_load_control_unit.sv
// weight_load_control_unit: streams FIFO weight rows into ping/pong shadow buffers and drives the weight-ready handshake (in: MAC_op_i, W_tiles_i, FIFO head, next_weight_tile_i; out: FIFO pop, row write port, rdy, done, underflow)
module weight_load_control_unit
  import tpu_package::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            MAC_op_i,
  input  logic [TILE_CNT_W-1:0] W_tiles_i,
  input  logic                  weight_fifo_valid_i,
  input  weight_row_t           weight_fifo_data_i,
  input  logic                  next_weight_tile_i,
  output logic                  weight_fifo_rd_o,
  output logic                  weight_row_wr_en_o,
  output weight_row_t           weight_row_o,
  output logic [ROW_IDX_W-1:0]  weight_row_idx_o,
  output logic                  weight_buf_sel_o,
  output logic                  compute_weights_rdy_o,
  output logic                  load_done_o,
  output logic                  underflow_err_o
);
  wl_state_t state, state_d;
  logic [ROW_IDX_W-1:0] row_cntr;
  logic [TILE_CNT_W-1:0] tiles_total, tiles_loaded;
  logic [1:0] full_cnt;
  logic wr_buf, rd_buf, pop, tile_last, last_tile, unused;
  assign pop = state == LOAD && weight_fifo_valid_i;
  assign weight_fifo_rd_o = pop;
  assign tile_last = pop && row_cntr == LAST_ROW;
  assign last_tile = tiles_loaded + TILE_CNT_W'(1) == tiles_total;
  assign load_done_o = state == DONE && full_cnt == 2'd0;
  assign unused = ^{MAC_op_i[2:1], rd_buf};
  pingpong_occupancy_tracker u_occ (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tile_loaded   (tile_last),
    .consume       (next_weight_tile_i),
    .full_cnt      (full_cnt),
    .wr_buf        (wr_buf),
    .rd_buf        (rd_buf),
    .underflow_err (underflow_err_o)
  );
  always_comb begin
    state_d = state;
    case (state)
      RESET:     if (!MAC_op_i[0]) state_d = W_tiles_i == '0 ? DONE : IDLE;
      IDLE:      state_d = LOAD;
      LOAD:      if (tile_last) state_d = last_tile ? DONE : (full_cnt != 2'd0 && !next_weight_tile_i) ? WAIT_FREE : IDLE;
      WAIT_FREE: if (full_cnt < 2'd2) state_d = IDLE;
      default:   state_d = state;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RESET;
      row_cntr <= '0;
      tiles_total <= '0;
      tiles_loaded <= '0;
      weight_row_wr_en_o <= 1'b0;
      weight_row_o <= '0;
      weight_row_idx_o <= '0;
      weight_buf_sel_o <= 1'b0;
      compute_weights_rdy_o <= 1'b0;
    end else begin
      state <= state_d;
      row_cntr <= state == IDLE ? '0 : row_cntr + ROW_IDX_W'(pop);
      tiles_loaded <= state == RESET ? '0 : tiles_loaded + TILE_CNT_W'(tile_last);
      if (state == RESET && !MAC_op_i[0]) tiles_total <= W_tiles_i;
      weight_row_wr_en_o <= pop;
      if (pop) begin
        weight_row_o <= weight_fifo_data_i;
        weight_row_idx_o <= row_cntr;
        weight_buf_sel_o <= wr_buf;
      end
      compute_weights_rdy_o <= full_cnt != 2'd0;
    end
  end
endmodule

// File: tb/tb_weight_load_control_unit.sv
// tb_weight_load_control_unit: directed self-checking bench for weight_load_control_unit
module tb_weight_load_control_unit;
  import tpu_package::*;
  logic clk = 1'b0;
  logic rst, nxt, fv, fifo_rd, wr_en, sel, rdy, done, uerr;
  logic [2:0] mac_op;
  logic [TILE_CNT_W-1:0] w_tiles;
  weight_row_t fd, row;
  logic [ROW_IDX_W-1:0] idx;
  int checks = 0;
  int failures = 0;
  int nwr, exp_idx, used;
  logic exp_sel;
  always #5 clk = ~clk;
  weight_load_control_unit dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .MAC_op_i              (mac_op),
    .W_tiles_i             (w_tiles),
    .weight_fifo_valid_i   (fv),
    .weight_fifo_data_i    (fd),
    .next_weight_tile_i    (nxt),
    .weight_fifo_rd_o      (fifo_rd),
    .weight_row_wr_en_o    (wr_en),
    .weight_row_o          (row),
    .weight_row_idx_o      (idx),
    .weight_buf_sel_o      (sel),
    .compute_weights_rdy_o (rdy),
    .load_done_o           (done),
    .underflow_err_o       (uerr)
  );
  function automatic weight_row_t mkrow(input int k);
    weight_row_t r;
    for (int i = 0; i < MUL_SIZE; i++) r[i*DATA_W +: DATA_W] = DATA_W'(k * 7 + i + 3);
    return r;
  endfunction
  task automatic chk(input string tag, input weight_row_t obs, input weight_row_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    nwr = 0;
    exp_idx = 0;
    exp_sel = 1'b0;
    fd = mkrow(0);
  endtask
  task automatic cyc();
    logic p, r;
    weight_row_t d;
    @(negedge clk);
    p = fifo_rd;
    r = rst;
    d = fd;
    @(posedge clk);
    #1;
    if (r) chk("wr_en_in_reset", weight_row_t'(wr_en), weight_row_t'(0));
    else if (p) begin
      chk("wr_en", weight_row_t'(wr_en), weight_row_t'(1));
      chk("row_idx", weight_row_t'(idx), weight_row_t'(exp_idx));
      chk("buf_sel", weight_row_t'(sel), weight_row_t'(exp_sel));
      chk("row_data", row, d);
      nwr++;
      exp_idx = (exp_idx + 1) % MUL_SIZE;
      if (exp_idx == 0) exp_sel = ~exp_sel;
      fd = mkrow(nwr);
    end else chk("wr_en_no_pop", weight_row_t'(wr_en), weight_row_t'(0));
  endtask
  task automatic run_to(input int target, input int bound, input bit tog, output int n);
    n = 0;
    while (nwr < target && n < bound) begin
      cyc();
      n++;
      if (tog) fv = ~fv;
    end
    chk("writes_reached", weight_row_t'(nwr), weight_row_t'(target));
  endtask
  task automatic consume();
    nxt = 1'b1;
    cyc();
    nxt = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    mac_op = 3'b001;
    fv = 1'b0;
    nxt = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    model_clear();
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"}, weight_row_t'(fifo_rd), weight_row_t'(0));
    chk({tag, "_wr_en"}, weight_row_t'(wr_en), weight_row_t'(0));
    chk({tag, "_row"}, row, weight_row_t'(0));
    chk({tag, "_idx"}, weight_row_t'(idx), weight_row_t'(0));
    chk({tag, "_sel"}, weight_row_t'(sel), weight_row_t'(0));
    chk({tag, "_rdy"}, weight_row_t'(rdy), weight_row_t'(0));
    chk({tag, "_done"}, weight_row_t'(done), weight_row_t'(0));
    chk({tag, "_uerr"}, weight_row_t'(uerr), weight_row_t'(0));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    w_tiles = '0;
    model_clear();
    do_reset();
    chk_all_zero("reset");
    mac_op = 3'b000;
    w_tiles = 9'd1;
    fv = 1'b1;
    cyc();
    cyc();
    chk("t1_rd_in_load", weight_row_t'(fifo_rd), weight_row_t'(1));
    run_to(32, 40, 1'b0, used);
    chk("t1_cycles", weight_row_t'(used), weight_row_t'(32));
    chk("t1_rdy_after_last_pop", weight_row_t'(rdy), weight_row_t'(0));
    chk("t1_done_before_consume", weight_row_t'(done), weight_row_t'(0));
    cyc();
    chk("t1_rdy_rise", weight_row_t'(rdy), weight_row_t'(1));
    chk("t1_no_pop_done", weight_row_t'(fifo_rd), weight_row_t'(0));
    consume();
    chk("t1_done", weight_row_t'(done), weight_row_t'(1));
    cyc();
    chk("t1_rdy_fall", weight_row_t'(rdy), weight_row_t'(0));
    chk("t1_done_held", weight_row_t'(done), weight_row_t'(1));
    chk("t1_uerr", weight_row_t'(uerr), weight_row_t'(0));
    do_reset();
    mac_op = 3'b000;
    w_tiles = 9'd3;
    fv = 1'b1;
    cyc();
    cyc();
    run_to(64, 80, 1'b0, used);
    chk("t2_two_tiles_cycles", weight_row_t'(used), weight_row_t'(65));
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_wait_free_no_pop", weight_row_t'(fifo_rd), weight_row_t'(0));
      chk("t2_wait_free_rdy", weight_row_t'(rdy), weight_row_t'(1));
    end
    consume();
    run_to(96, 40, 1'b0, used);
    chk("t2_tile2_cycles", weight_row_t'(used), weight_row_t'(34));
    chk("t2_done_full2", weight_row_t'(done), weight_row_t'(0));
    cyc();
    chk("t2_no_pop_done", weight_row_t'(fifo_rd), weight_row_t'(0));
    consume();
    cyc();
    chk("t2_done_full1", weight_row_t'(done), weight_row_t'(0));
    chk("t2_rdy_full1", weight_row_t'(rdy), weight_row_t'(1));
    consume();
    chk("t2_done", weight_row_t'(done), weight_row_t'(1));
    cyc();
    chk("t2_rdy_fall", weight_row_t'(rdy), weight_row_t'(0));
    chk("t2_uerr", weight_row_t'(uerr), weight_row_t'(0));
    do_reset();
    mac_op = 3'b000;
    w_tiles = 9'd1;
    cyc();
    cyc();
    fv = 1'b1;
    run_to(32, 80, 1'b1, used);
    chk("t3_bubble_cycles", weight_row_t'(used), weight_row_t'(63));
    do_reset();
    mac_op = 3'b000;
    w_tiles = 9'd3;
    fv = 1'b1;
    cyc();
    cyc();
    run_to(63, 80, 1'b0, used);
    chk("t4_rd_before_last", weight_row_t'(fifo_rd), weight_row_t'(1));
    chk("t4_rdy_before", weight_row_t'(rdy), weight_row_t'(1));
    consume();
    chk("t4_rdy_same_cycle", weight_row_t'(rdy), weight_row_t'(1));
    cyc();
    chk("t4_rdy_stays", weight_row_t'(rdy), weight_row_t'(1));
    run_to(96, 40, 1'b0, used);
    chk("t4_tile2_cycles", weight_row_t'(used), weight_row_t'(32));
    chk("t4_done_full2", weight_row_t'(done), weight_row_t'(0));
    consume();
    consume();
    chk("t4_done", weight_row_t'(done), weight_row_t'(1));
    do_reset();
    consume();
    chk("t5_uerr_set", weight_row_t'(uerr), weight_row_t'(1));
    chk("t5_rdy", weight_row_t'(rdy), weight_row_t'(0));
    cyc();
    cyc();
    chk("t5_uerr_sticky", weight_row_t'(uerr), weight_row_t'(1));
    chk("t5_rdy_still0", weight_row_t'(rdy), weight_row_t'(0));
    mac_op = 3'b000;
    w_tiles = 9'd1;
    fv = 1'b1;
    cyc();
    cyc();
    run_to(32, 40, 1'b0, used);
    cyc();
    chk("t5_rdy_after_load", weight_row_t'(rdy), weight_row_t'(1));
    chk("t5_done_full1", weight_row_t'(done), weight_row_t'(0));
    consume();
    cyc();
    chk("t5_done", weight_row_t'(done), weight_row_t'(1));
    chk("t5_rdy_fall", weight_row_t'(rdy), weight_row_t'(0));
    chk("t5_uerr_held", weight_row_t'(uerr), weight_row_t'(1));
    do_reset();
    mac_op = 3'b000;
    w_tiles = 9'd2;
    fv = 1'b1;
    cyc();
    cyc();
    run_to(11, 20, 1'b0, used);
    rst = 1'b1;
    cyc();
    chk_all_zero("t6_midtile_reset");
    model_clear();
    rst = 1'b0;
    cyc();
    cyc();
    run_to(32, 40, 1'b0, used);
    chk("t6_restart_cycles", weight_row_t'(used), weight_row_t'(32));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    w_tiles = 9'd0;
    cyc();
    chk("t6_zero_tiles_done", weight_row_t'(done), weight_row_t'(1));
    for (int i = 0; i < 3; i++) begin
      chk("t6_zero_tiles_no_pop", weight_row_t'(fifo_rd), weight_row_t'(0));
      cyc();
    end
    chk("t6_zero_tiles_done_held", weight_row_t'(done), weight_row_t'(1));
    chk("t6_zero_tiles_no_writes", weight_row_t'(nwr), weight_row_t'(32));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/weight_load_control_unit.md
Name: weight_load_control_unit

Overview:
- Producer side of the weight-ready handshake for the MUL_SIZE x MUL_SIZE systolic MAC array.
- Streams weight tiles row by row from the weight FIFO (first-word-fall-through) into the two ping/pong weight shadow buffers.
- Asserts compute_weights_rdy_o while at least one loaded tile is unconsumed.
- Frees a buffer each time the compute controller pulses next_weight_tile_i.

Parameters:
MUL_SIZE, 32, array dimension; rows per tile and lanes per row
DATA_W, 8, bits per weight element
TILE_CNT_W, 9, width of the tile count and tile counters

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  synchronous, active-high reset
MAC_op_i  in  3  op code; bit0=1 holds the block in RESET
W_tiles_i  in  TILE_CNT_W  weight tiles in this op; sampled on leaving RESET
weight_fifo_valid_i  in  1  FIFO head holds a valid row
weight_fifo_data_i  in  MUL_SIZE*DATA_W  FIFO head row
next_weight_tile_i  in  1  one-cycle pulse from compute: active tile consumed
weight_fifo_rd_o  out  1  pop FIFO head (same-cycle handshake)
weight_row_wr_en_o  out  1  write weight_row_o into the shadow buffer
weight_row_o  out  MUL_SIZE*DATA_W  registered row data
weight_row_idx_o  out  $clog2(MUL_SIZE)  target row; 0 first
weight_buf_sel_o  out  1  buffer being written (0/1)
compute_weights_rdy_o  out  1  at least one full, unconsumed buffer
load_done_o  out  1  all tiles loaded and consumed; held until RESET
underflow_err_o  out  1  sticky; consume seen with no full buffer

Behaviour:
- Reset values (rst_i=1, any cycle): state=RESET and all outputs 0. full_cnt=0, row_cntr=0, tiles_loaded=0, wr_buf=0 and rd_buf=0. A partially loaded tile is discarded; there is no recovery.
- States: RESET, IDLE, LOAD, WAIT_FREE, DONE.
- RESET: if !MAC_op_i[0], latch W_tiles_i into tiles_total. Go to DONE if it is 0, otherwise go to IDLE.
- IDLE: one cycle, then go to LOAD. Clear row_cntr.
- LOAD: weight_fifo_rd_o = weight_fifo_valid_i (combinational, LOAD only).
  - On each pop, next cycle: weight_row_wr_en_o=1, weight_row_o=data, weight_row_idx_o=row_cntr, weight_buf_sel_o=wr_buf. Then row_cntr++.
  - A FIFO bubble gives no write; the row counter holds.
  - On the pop with row_cntr==MUL_SIZE-1: tile complete.
    - Next cycle: full_cnt++, wr_buf toggles, tiles_loaded++.
    - Next state: DONE-wait if tiles_loaded+1==tiles_total. Otherwise WAIT_FREE if full_cnt after update == 2, else IDLE.
- WAIT_FREE: no FIFO pops. Go to IDLE when full_cnt<2.
- Consume: next_weight_tile_i with full_cnt>0 decrements full_cnt and toggles rd_buf. With full_cnt==0 it is ignored and underflow_err_o is set (sticky until reset).
- Simultaneous tile completion and consume in the same cycle: full_cnt unchanged, both buffer pointers toggle.
- compute_weights_rdy_o = registered (full_cnt!=0). It updates the cycle after the full_cnt change: rdy rises 2 cycles after the last row pop and falls 1 cycle after the consuming pulse.
- DONE: no pops. load_done_o=1 once full_cnt==0. Leave DONE only via rst_i.
- full_cnt is 2 bits and saturates at 2 by construction; loading never overwrites a full buffer.

Decomposition:
- tpu_package: MUL_SIZE, DATA_W, TILE_CNT_W, the state enum type wl_state_t, and the row type weight_row_t (logic [MUL_SIZE*DATA_W-1:0]).
- Sub-module pingpong_occupancy_tracker owns full_cnt, wr_buf, rd_buf and underflow_err_o.
  - Inputs: tile_loaded, consume.
  - Outputs: full_cnt, pointers, err.
  - Reused by the activation path.

Test Plan:
- W_tiles=1, FIFO always valid: 32 pops, row_idx 0..31, buf_sel=0. rdy rises 2 cycles after the 32nd pop. Pulse consume: rdy falls next cycle, load_done_o=1.
- W_tiles=3, no consumes: tiles 0 and 1 loaded into buf 0 then 1; full_cnt=2, no pops, state WAIT_FREE. One consume: tile 2 loads into buf 0; done after 2 more consumes.
- FIFO valid toggling every other cycle, W_tiles=1: exactly 32 writes, idx strictly incrementing, no write during bubbles, 63 cycles to tile complete.
- Consume pulsed on the same cycle as tile 1 completion (full_cnt=1): full_cnt stays 1, rdy stays 1, rd_buf=1, wr_buf=0.
- Consume with full_cnt=0: underflow_err_o=1 and stays 1; full_cnt stays 0.
- rst_i asserted after row 10 of tile 0: next cycle all outputs 0. After release with MAC_op_i[0]=0, loading restarts at row 0, buf 0. W_tiles=0 → load_done_o=1 with no pops.
